// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared widths, register-zero constant and sequencer state encoding
package rf_pkg;
  localparam int DW = 16;
  localparam int AW = 3;
  localparam logic [AW-1:0] REG_ZERO = 3'd0;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_WAIT = 3'd2,
    S_EXEC = 3'd3,
    S_WB   = 3'd4
  } state_e;

  function automatic logic wb_needed(input logic wb, input logic [AW-1:0] rd);
    return wb && (rd != REG_ZERO);
  endfunction
endpackage

// File: rtl/regfile_access_ctrl.sv
// rtl/regfile_access_ctrl.sv - one-instruction-at-a-time register file read/execute/writeback sequencer
module regfile_access_ctrl
  import rf_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_rs,
  input  logic [AW-1:0] req_rt,
  input  logic [AW-1:0] req_rd,
  input  logic          req_wb,
  output logic          op_valid,
  output logic [DW-1:0] op_a,
  output logic [DW-1:0] op_b,
  input  logic          res_valid,
  input  logic [DW-1:0] res_data,
  output logic          done,
  output logic [AW-1:0] ra1,
  output logic [AW-1:0] ra2,
  input  logic [DW-1:0] rd1,
  input  logic [DW-1:0] rd2,
  output logic [AW-1:0] wa,
  output logic [DW-1:0] wd,
  output logic          RegWrite
);

  state_e        state_q, state_d;
  logic [AW-1:0] ra1_q, ra1_d, ra2_q, ra2_d, wa_q, wa_d, rd_q, rd_d;
  logic          wb_q, wb_d, op_valid_q, op_valid_d, done_q, done_d, regwrite_q, regwrite_d;
  logic [DW-1:0] op_a_q, op_a_d, op_b_q, op_b_d, wd_q, wd_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ra1_q      <= '0;
      ra2_q      <= '0;
      wa_q       <= '0;
      rd_q       <= '0;
      wb_q       <= 1'b0;
      op_valid_q <= 1'b0;
      done_q     <= 1'b0;
      regwrite_q <= 1'b0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      wd_q       <= '0;
    end else begin
      state_q    <= state_d;
      ra1_q      <= ra1_d;
      ra2_q      <= ra2_d;
      wa_q       <= wa_d;
      rd_q       <= rd_d;
      wb_q       <= wb_d;
      op_valid_q <= op_valid_d;
      done_q     <= done_d;
      regwrite_q <= regwrite_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      wd_q       <= wd_d;
    end
  end

  // done and RegWrite default low so each is a single-cycle pulse
  always_comb begin
    state_d    = state_q;
    ra1_d      = ra1_q;
    ra2_d      = ra2_q;
    wa_d       = wa_q;
    rd_d       = rd_q;
    wb_d       = wb_q;
    op_valid_d = op_valid_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    wd_d       = wd_q;
    done_d     = 1'b0;
    regwrite_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          ra1_d   = req_rs;
          ra2_d   = req_rt;
          rd_d    = req_rd;
          wb_d    = req_wb;
          state_d = S_READ;
        end
      end
      S_READ: state_d = S_WAIT;
      S_WAIT: begin
        op_a_d     = rd1;
        op_b_d     = rd2;
        op_valid_d = 1'b1;
        state_d    = S_EXEC;
      end
      S_EXEC: begin
        if (res_valid) begin
          wd_d       = res_data;
          wa_d       = rd_q;
          op_valid_d = 1'b0;
          if (wb_needed(wb_q, rd_q)) begin
            regwrite_d = 1'b1;
            state_d    = S_WB;
          end else begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_WB: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign req_ready = (state_q == S_IDLE);
  assign op_valid  = op_valid_q;
  assign op_a      = op_a_q;
  assign op_b      = op_b_q;
  assign done      = done_q;
  assign ra1       = ra1_q;
  assign ra2       = ra2_q;
  assign wa        = wa_q;
  assign wd        = wd_q;
  assign RegWrite  = regwrite_q;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// tb/tb_regfile_access_ctrl.sv - directed and random bench with a behavioural register file responder
module tb_regfile_access_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_wb;
  logic [2:0]  req_rs, req_rt, req_rd;
  logic        op_valid, res_valid, done, RegWrite;
  logic [15:0] op_a, op_b, res_data, rd1, rd2, wd;
  logic [2:0]  ra1, ra2, wa;

  regfile_access_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd), .req_wb(req_wb),
    .op_valid(op_valid), .op_a(op_a), .op_b(op_b),
    .res_valid(res_valid), .res_data(res_data), .done(done),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .wa(wa), .wd(wd), .RegWrite(RegWrite)
  );

  always #5 clk = ~clk;

  logic [15:0] rf [8];
  logic        pre_we = 1'b0;
  logic [2:0]  pre_a = '0;
  logic [15:0] pre_d = '0;

  always @(posedge clk) begin
    if (pre_we) rf[pre_a] <= pre_d;
    else if (RegWrite && wa != 3'd0) rf[wa] <= wd;
    rd1 <= (ra1 == 3'd0) ? 16'h0 : rf[ra1];
    rd2 <= (ra2 == 3'd0) ? 16'h0 : rf[ra2];
  end

  int acc_cnt = 0, done_cnt = 0, wr_cnt = 0;
  always @(posedge clk) begin
    if (!rst && req_valid && req_ready) acc_cnt++;
    if (done) done_cnt++;
    if (RegWrite) wr_cnt++;
  end

  logic [15:0] model [8];
  int errors = 0, checks = 0, aborted = 0, exp_wr = 0;
  logic [2:0]  cur_rd;
  logic        cur_wb;
  logic [15:0] cur_a, cur_b;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rst(input string w);
    chk({w, "_ready"}, 32'(req_ready), 32'd1);
    chk({w, "_opv"}, 32'(op_valid), 32'd0);
    chk({w, "_done"}, 32'(done), 32'd0);
    chk({w, "_rw"}, 32'(RegWrite), 32'd0);
    chk({w, "_ra"}, {26'd0, ra1, ra2}, 32'd0);
    chk({w, "_wa_wd"}, {13'd0, wa, wd}, 32'd0);
    chk({w, "_ops"}, {op_a, op_b}, 32'd0);
  endtask

  // Called at a negedge; returns at the negedge where operands should be valid.
  task automatic issue(input logic [2:0] rs, rt, rd, input logic wb,
                       input logic [15:0] res, input logic hold);
    cur_rd = rd; cur_wb = wb;
    cur_a = model[rs]; cur_b = model[rt];
    chk("accept_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_rs = rs; req_rt = rt; req_rd = rd; req_wb = wb;
    if (hold) begin res_valid = 1'b1; res_data = res; end
    @(posedge clk); @(negedge clk);
    if (hold) begin req_rs = ~rs; req_rt = ~rt; req_rd = ~rd; req_wb = ~wb; end
    else req_valid = 1'b0;
    chk("read_addr", {26'd0, ra1, ra2}, {26'd0, rs, rt});
    chk("opv_lat1", 32'(op_valid), 32'd0);
    @(negedge clk);
    chk("opv_lat2", 32'(op_valid), 32'd0);
    chk("busy", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("opv_lat3", 32'(op_valid), 32'd1);
    chk("operands", {op_a, op_b}, {cur_a, cur_b});
  endtask

  task automatic complete(input logic [15:0] res, input int delay);
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      chk("op_hold", {op_valid, op_a}, {1'b1, cur_a});
    end
    res_valid = 1'b1; res_data = res;
    @(posedge clk); @(negedge clk);
    if (cur_wb && cur_rd != 3'd0) begin
      chk("wb_pulse", {28'd0, RegWrite, done, op_valid, 1'b0}, 32'h8);
      chk("wb_wa_wd", {13'd0, wa, wd}, {13'd0, cur_rd, res});
      @(negedge clk);
      model[cur_rd] = res;
      exp_wr++;
    end
    chk("retire", {29'd0, RegWrite, done, op_valid}, 32'h2);
    chk("ret_wa_wd", {13'd0, wa, wd}, {13'd0, cur_rd, res});
    chk("rf_dest", 32'(rf[cur_rd]), 32'(model[cur_rd]));
    req_valid = 1'b0; res_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; res_valid = 1'b0; req_wb = 1'b0;
    req_rs = '0; req_rt = '0; req_rd = '0; res_data = '0;
    for (int i = 0; i < 8; i++) model[i] = (i == 0) ? 16'h0 : 16'($urandom);
    model[3] = 16'h1234; model[5] = 16'h00FF;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); pre_we = 1'b1; pre_a = 3'(i); pre_d = model[i];
    end
    @(negedge clk); pre_we = 1'b0;
    chk_rst("por");
    rst = 1'b0;

    // 1: basic read/execute/writeback
    issue(3'd3, 3'd5, 3'd6, 1'b1, 16'h0, 1'b0);
    chk("t1_opa", 32'(op_a), 32'h1234);
    complete(16'hBEEF, 1);
    chk("t1_r6", 32'(rf[6]), 32'hBEEF);
    // 2: destination r0 never written
    issue(3'd0, 3'd6, 3'd0, 1'b1, 16'h0, 1'b0);
    complete(16'hDEAD, 0);
    chk("t2_r0", 32'(rf[0]), 32'h0);
    // 3: store, no writeback
    issue(3'd6, 3'd0, 3'd4, 1'b0, 16'h0, 1'b0);
    complete(16'h5555, 2);
    // 4: back-to-back read-after-write
    issue(3'd1, 3'd1, 3'd2, 1'b1, 16'h0, 1'b0);
    complete(16'h0A0A, 0);
    issue(3'd2, 3'd0, 3'd3, 1'b0, 16'h0, 1'b0);
    chk("t4_opa", 32'(op_a), 32'h0A0A);
    complete(16'h1111, 0);

    // 5a: reset during EXEC aborts the write
    issue(3'd3, 3'd5, 3'd4, 1'b1, 16'h0, 1'b0);
    rst = 1'b1; res_valid = 1'b1; res_data = 16'hCAFE;
    @(posedge clk); @(negedge clk);
    rst = 1'b0; res_valid = 1'b0; aborted++;
    chk_rst("rst_exec");
    chk("rst_exec_r4", 32'(rf[4]), 32'(model[4]));
    // 5b: reset during WB; the write in flight commits at that edge
    issue(3'd5, 3'd3, 3'd7, 1'b1, 16'h0, 1'b0);
    res_valid = 1'b1; res_data = 16'h7777;
    @(posedge clk); @(negedge clk);
    res_valid = 1'b0;
    chk("wb_before_rst", 32'(RegWrite), 32'd1);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0; aborted++; exp_wr++; model[7] = 16'h7777;
    chk_rst("rst_wb");
    chk("rst_wb_r7", 32'(rf[7]), 32'h7777);

    // 6: res_valid and req_valid held high while busy
    issue(3'd7, 3'd3, 3'd1, 1'b1, 16'h4242, 1'b1);
    complete(16'h4242, 0);
    issue(3'd1, 3'd7, 3'd5, 1'b0, 16'h9999, 1'b1);
    complete(16'h9999, 0);

    for (int n = 0; n < 40; n++) begin
      logic hold;
      logic [15:0] res;
      hold = 1'($urandom);
      res = 16'($urandom);
      issue(3'($urandom), 3'($urandom), 3'($urandom), 1'($urandom), res, hold);
      complete(res, hold ? 0 : int'($urandom_range(0, 3)));
    end

    repeat (3) @(negedge clk);
    chk("done_per_accept", 32'(done_cnt), 32'(acc_cnt - aborted));
    chk("write_count", 32'(wr_cnt), 32'(exp_wr));
    for (int i = 0; i < 8; i++) chk("rf_final", 32'(rf[i]), 32'(model[i]));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
